timer_scheduler: RTL and testbench

- Round-robin scheduler that shares one prescaled delay timer among NREQ requesters.
- Each requester asks for a delay of dly ticks, where one tick is m+1 clocks.
- The block arbitrates between requesters, loads and runs its internal prescaler and tick counter for the winner, then pulses that requester's done.
- Sits between software/control FSMs needing timed waits (display refresh, sensor poll intervals) and the timing datapath.

---
 rtl/timer_scheduler.sv | 145 ++++++++++++++
 tb/tb_timer_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one prescaled delay timer among NREQ requesters.
// The winner's m and dly are latched at grant. The timer then runs for
// dly*(m+1) clocks, and the winner gets a one-cycle done pulse with its grant
// still held. All outputs are registered.
module timer_scheduler #(
  parameter int M_BITS = 8,
  parameter int N_BITS = 4,
  parameter int NREQ   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [M_BITS-1:0]        m,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*N_BITS-1:0]   dly,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy
);

  // state | meaning
  // IDLE  | no grant; arbitrate among pending requests
  // RUN   | prescaler and tick counter running for the granted requester
  // DONE  | one-cycle done pulse to the granted requester
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt, sel, sel_nxt, win, sel_inc;
  logic              found;
  logic [M_BITS-1:0] q, q_nxt, m_lat, m_lat_nxt;
  logic [N_BITS-1:0] cnt, cnt_nxt, dly_lat, dly_lat_nxt, dly_win;
  logic [NREQ-1:0]   gnt_nxt, done_nxt;
  logic              busy_nxt;

  // Round-robin pick: first requester at or above the pointer, with wrap.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  assign dly_win = dly[int'(win)*N_BITS +: N_BITS];
  assign sel_inc = (sel == PW'(NREQ-1)) ? '0 : sel + 1'b1;

  // Next-state, timer and registered-output values.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    q_nxt       = q;
    cnt_nxt     = cnt;
    m_lat_nxt   = m_lat;
    dly_lat_nxt = dly_lat;
    gnt_nxt     = gnt;
    done_nxt    = '0;
    busy_nxt    = busy;
    case (state)
      IDLE: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
        if (found) begin
          sel_nxt     = win;
          m_lat_nxt   = m;
          dly_lat_nxt = dly_win;
          q_nxt       = '0;
          cnt_nxt     = '0;
          gnt_nxt     = NREQ'(1) << win;
          busy_nxt    = 1'b1;
          if (dly_win == '0) begin
            state_nxt = DONE;
            done_nxt  = NREQ'(1) << win;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        // Abort takes priority over a tick landing in the same cycle.
        if (!req[sel]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = sel_inc;
        end else if (q == m_lat) begin
          q_nxt   = '0;
          cnt_nxt = cnt + 1'b1;
          if (cnt == dly_lat - 1'b1) begin
            state_nxt = DONE;
            done_nxt  = gnt;
          end
        end else begin
          q_nxt = q + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        ptr_nxt   = sel_inc;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, timer and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      sel     <= '0;
      q       <= '0;
      cnt     <= '0;
      m_lat   <= '0;
      dly_lat <= '0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      sel     <= sel_nxt;
      q       <= q_nxt;
      cnt     <= cnt_nxt;
      m_lat   <= m_lat_nxt;
      dly_lat <= dly_lat_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler. Each scenario task checks {gnt,done,busy}
// #1 after each rising edge and drives inputs at the same point.
module tb_timer_scheduler;
  localparam int M_BITS = 8;
  localparam int N_BITS = 4;
  localparam int NREQ   = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [M_BITS-1:0]      m;
  logic [NREQ-1:0]        req;
  logic [NREQ*N_BITS-1:0] dly;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic                   busy;

  int tests = 0;
  int fails = 0;

  timer_scheduler #(.M_BITS(M_BITS), .N_BITS(N_BITS), .NREQ(NREQ)) dut (
    .clk  (clk),
    .reset(reset),
    .m    (m),
    .req  (req),
    .dly  (dly),
    .gnt  (gnt),
    .done (done),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; m = '0; dly = '0;
    #3;
    tests++;
    if ({gnt, done, busy} !== 9'b0) begin
      fails++;
      $display("FAIL reset_hold: gnt/done/busy got %b_%b_%b want 0000_0000_0", gnt, done, busy);
    end
    step(); step();
    reset = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      tests++;
      if ({gnt, done, busy} !== 9'b0) begin
        fails++;
        $display("FAIL idle[%0d]: gnt/done/busy got %b_%b_%b want 0000_0000_0", j, gnt, done, busy);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] eg, ed;
    logic       eb;
    m = 8'd3; dly = 16'h0002; req = 4'b0001;
    for (int j = 1; j <= 11; j++) begin
      step();
      eg = (j <= 9) ? 4'b0001 : 4'b0000;
      ed = (j == 9) ? 4'b0001 : 4'b0000;
      eb = (j <= 9);
      tests++;
      if ({gnt, done, busy} !== {eg, ed, eb}) begin
        fails++;
        $display("FAIL single[%0d]: gnt/done/busy got %b_%b_%b want %b_%b_%b", j, gnt, done, busy, eg, ed, eb);
      end
      if (j == 9) req = 4'b0000;
    end
  endtask

  task automatic test_contention();
    logic [3:0] eg, ed;
    logic       eb;
    int         ph, ch;
    logic [8:0] tab [6] = '{9'b0010_0000_1, 9'b0010_0010_1, 9'b0000_0000_0,
                            9'b1000_0000_1, 9'b1000_1000_1, 9'b0000_0000_0};
    reset = 1'b0; step(); reset = 1'b1;
    m = 8'd0; dly = 16'h1111; req = 4'b1111;
    for (int j = 1; j <= 15; j++) begin
      step();
      ph = (j - 1) % 3;
      ch = ((j - 1) / 3) % 4;
      eg = (ph < 2)  ? (4'b0001 << ch) : 4'b0000;
      ed = (ph == 1) ? (4'b0001 << ch) : 4'b0000;
      eb = (ph < 2);
      tests++;
      if ({gnt, done, busy} !== {eg, ed, eb}) begin
        fails++;
        $display("FAIL rr[%0d]: gnt/done/busy got %b_%b_%b want %b_%b_%b", j, gnt, done, busy, eg, ed, eb);
      end
    end
    req = 4'b1010;
    for (int j = 0; j < 6; j++) begin
      step();
      tests++;
      if ({gnt, done, busy} !== tab[j]) begin
        fails++;
        $display("FAIL rr_1010[%0d]: gnt_done_busy got %b want %b", j, {gnt, done, busy}, tab[j]);
      end
      if (j == 4) req = 4'b0000;
    end
  endtask

  task automatic test_zero_delay();
    logic [8:0] tab [3] = '{9'b0100_0100_1, 9'b0, 9'b0};
    m = 8'd0; dly = 16'h0000; req = 4'b0100;
    for (int j = 0; j < 3; j++) begin
      step();
      tests++;
      if ({gnt, done, busy} !== tab[j]) begin
        fails++;
        $display("FAIL zero_dly[%0d]: gnt_done_busy got %b want %b", j, {gnt, done, busy}, tab[j]);
      end
      req = 4'b0000;
    end
  endtask

  task automatic test_abort();
    logic [8:0] tab [3] = '{9'b1000_0000_1, 9'b1000_1000_1, 9'b0};
    m = 8'd7; dly = 16'h0040; req = 4'b0010;
    for (int j = 1; j <= 40; j++) begin
      step();
      tests++;
      if (j <= 6) begin
        if ({gnt, done, busy} !== 9'b0010_0000_1) begin
          fails++;
          $display("FAIL abort_run[%0d]: gnt_done_busy got %b want 001000001", j, {gnt, done, busy});
        end
      end else if ({gnt, done, busy} !== 9'b0) begin
        fails++;
        $display("FAIL abort_after[%0d]: gnt_done_busy got %b want 000000000", j, {gnt, done, busy});
      end
      if (j == 6) req = 4'b0000;
    end
    m = 8'd0; dly = 16'h1111; req = 4'b1011;
    for (int j = 0; j < 3; j++) begin
      step();
      tests++;
      if ({gnt, done, busy} !== tab[j]) begin
        fails++;
        $display("FAIL abort_ptr[%0d]: gnt_done_busy got %b want %b", j, {gnt, done, busy}, tab[j]);
      end
      if (j == 1) req = 4'b0000;
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] pre [3]  = '{9'b0010_0000_1, 9'b0010_0010_1, 9'b0};
    logic [8:0] post [3] = '{9'b0001_0000_1, 9'b0001_0001_1, 9'b0};
    m = 8'd0; dly = 16'h1111; req = 4'b0010;
    for (int j = 0; j < 3; j++) begin
      step();
      tests++;
      if ({gnt, done, busy} !== pre[j]) begin
        fails++;
        $display("FAIL ar_pre[%0d]: gnt_done_busy got %b want %b", j, {gnt, done, busy}, pre[j]);
      end
      if (j == 1) req = 4'b0000;
    end
    m = 8'd7; dly = 16'h0400; req = 4'b0100;
    for (int j = 0; j < 4; j++) begin
      step();
      tests++;
      if ({gnt, done, busy} !== 9'b0100_0000_1) begin
        fails++;
        $display("FAIL ar_run[%0d]: gnt_done_busy got %b want 010000001", j, {gnt, done, busy});
      end
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({gnt, done, busy} !== 9'b0) begin
      fails++;
      $display("FAIL ar_async: gnt_done_busy got %b want 000000000", {gnt, done, busy});
    end
    step();
    req = 4'b0000;
    reset = 1'b1;
    for (int j = 0; j < 40; j++) begin
      step();
      tests++;
      if ({gnt, done, busy} !== 9'b0) begin
        fails++;
        $display("FAIL ar_quiet[%0d]: gnt_done_busy got %b want 000000000", j, {gnt, done, busy});
      end
    end
    m = 8'd0; dly = 16'h1111; req = 4'b1111;
    for (int j = 0; j < 3; j++) begin
      step();
      tests++;
      if ({gnt, done, busy} !== post[j]) begin
        fails++;
        $display("FAIL ar_post[%0d]: gnt_done_busy got %b want %b", j, {gnt, done, busy}, post[j]);
      end
      if (j == 1) req = 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero_delay();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
